// File: rtl/blocks_collide.sv
// Breakout-style collision scanner: walks the 15-entry block-position ROM once per
// start request and retires the lowest-indexed live block that the latched ball overlaps.
module blocks_collide #(
  parameter int unsigned BLOCK_W = 80,
  parameter int unsigned BLOCK_H = 8,
  parameter int unsigned BALL_SZ = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        restart,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  output logic [3:0]  rom_addr,
  input  logic [18:0] rom_q,
  output logic [14:0] alive,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [3:0]  hit_idx,
  output logic        cleared
);

  localparam int unsigned NBLK = 15;
  localparam int unsigned IDXW = 4;
  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned SW   = 11;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NBLK - 1);
  localparam logic [NBLK-1:0] ALL_ALIVE = {NBLK{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, SCAN, DONE} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     bx_q, bx_d;
  logic [YW-1:0]     by_q, by_d;
  logic [IDXW-1:0]   rom_addr_q, rom_addr_d;
  logic [IDXW-1:0]   eval_idx_q, eval_idx_d;
  logic              found_q, found_d;
  logic [IDXW-1:0]   found_idx_q, found_idx_d;
  logic [NBLK-1:0]   alive_q, alive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic [IDXW-1:0]   hit_idx_q, hit_idx_d;
  logic              cleared_q, cleared_d;

  logic [XW-1:0]     blk_x_c;
  logic [YW-1:0]     blk_y_c;
  logic              overlap_c;
  logic              cand_c;
  logic              found_n_c;
  logic [IDXW-1:0]   found_idx_n_c;

  // Strict-inequality box overlap between the latched ball and the block on rom_q
  always_comb begin
    blk_x_c   = rom_q[18:9];
    blk_y_c   = rom_q[8:0];
    overlap_c = (SW'(bx_q) < SW'(blk_x_c) + SW'(BLOCK_W)) &&
                (SW'(bx_q) + SW'(BALL_SZ) > SW'(blk_x_c)) &&
                (SW'(by_q) < SW'(blk_y_c) + SW'(BLOCK_H)) &&
                (SW'(by_q) + SW'(BALL_SZ) > SW'(blk_y_c));
    cand_c        = (state_q == SCAN) && alive_q[eval_idx_q] && overlap_c;
    found_n_c     = found_q | cand_c;
    found_idx_n_c = found_q ? found_idx_q : eval_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ISSUE;
        ISSUE:   state_d = SCAN;
        SCAN:    if (eval_idx_q == LAST_IDX) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bx_d        = bx_q;
    by_d        = by_q;
    eval_idx_d  = eval_idx_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    alive_d     = alive_q;
    done_d      = 1'b0;
    hit_d       = 1'b0;
    hit_idx_d   = hit_idx_q;
    if (restart) begin
      alive_d    = ALL_ALIVE;
      found_d    = 1'b0;
      eval_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bx_d = ball_x;
            by_d = ball_y;
          end
        end
        ISSUE: begin
          eval_idx_d = '0;
          found_d    = 1'b0;
        end
        SCAN: begin
          found_d     = found_n_c;
          found_idx_d = found_idx_n_c;
          if (eval_idx_q == LAST_IDX) begin
            done_d = 1'b1;
            hit_d  = found_n_c;
            if (found_n_c) begin
              hit_idx_d = found_idx_n_c;
              alive_d   = alive_q & ~(NBLK'(1) << found_idx_n_c);
            end
          end else begin
            eval_idx_d = eval_idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
    // Address runs one ahead of the block under evaluation and parks at 0
    rom_addr_d = ((state_d == SCAN) && (eval_idx_d < LAST_IDX)) ?
                 eval_idx_d + IDXW'(1) : '0;
    busy_d     = (state_d != IDLE);
    cleared_d  = (alive_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q        <= '0;
      by_q        <= '0;
      rom_addr_q  <= '0;
      eval_idx_q  <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      alive_q     <= ALL_ALIVE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      cleared_q   <= 1'b0;
    end else begin
      bx_q        <= bx_d;
      by_q        <= by_d;
      rom_addr_q  <= rom_addr_d;
      eval_idx_q  <= eval_idx_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      alive_q     <= alive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      cleared_q   <= cleared_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign alive    = alive_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign hit_idx  = hit_idx_q;
  assign cleared  = cleared_q;

endmodule

// File: tb/tb_blocks_collide.sv
// Bench for blocks_collide: directed and random scans checked cycle by cycle against
// a geometric model of the 3x5 block wall.
module tb_blocks_collide;

  localparam int BW = 80;
  localparam int BH = 8;
  localparam int BS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        restart;
  logic [9:0]  ball_x;
  logic [8:0]  ball_y;
  logic [3:0]  rom_addr;
  logic [18:0] rom_q;
  logic [14:0] alive;
  logic        busy;
  logic        done;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        cleared;

  logic [18:0] rom_tbl [16];

  int          vecs = 0;
  int          errs = 0;
  logic [14:0] alive_m;
  int          last_idx;

  blocks_collide #(.BLOCK_W(BW), .BLOCK_H(BH), .BALL_SZ(BS)) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .ball_x(ball_x), .ball_y(ball_y), .rom_addr(rom_addr), .rom_q(rom_q),
    .alive(alive), .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
    .cleared(cleared)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_tbl[rom_addr];

  function automatic int blk_x(input int k);
    return 100 + 90 * (k % 5);
  endfunction

  function automatic int blk_y(input int k);
    return 320 + 8 * (k / 5);
  endfunction

  // Lowest live overlapping block wins and is removed
  function automatic void model(input logic [14:0] al, input int x, input int y,
                                output logic h, output int idx, output logic [14:0] al_o);
    h = 1'b0;
    idx = 0;
    for (int k = 0; k < 15; k++) begin
      if (!h && al[k] && x < blk_x(k) + BW && x + BS > blk_x(k) &&
          y < blk_y(k) + BH && y + BS > blk_y(k)) begin
        h = 1'b1;
        idx = k;
      end
    end
    al_o = al;
    if (h) al_o[idx] = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan; pulse_edge>0 re-pulses start at that edge, alt_x>=0 moves the ball mid-scan
  task automatic run_scan(input int x, input int y, input int pulse_edge, input int alt_x);
    logic        eh;
    int          ei;
    logic [14:0] ea;
    model(alive_m, x, y, eh, ei, ea);
    @(negedge clk);
    ball_x = 10'(x);
    ball_y = 9'(y);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    chk("addr_e0", 32'(rom_addr), 32'd0);
    for (int e = 1; e <= 17; e++) begin
      start = (e == pulse_edge);
      if (e == 2 && alt_x >= 0) ball_x = 10'(alt_x);
      @(posedge clk); #1;
      start = 1'b0;
      if (e <= 15) begin
        chk("addr", 32'(rom_addr), (e <= 14) ? 32'(e) : 32'd0);
        chk("done_early", 32'(done), 32'd0);
        chk("busy_scan", 32'(busy), 32'd1);
      end else if (e == 16) begin
        chk("done", 32'(done), 32'd1);
        chk("hit", 32'(hit), 32'(eh));
        chk("hit_idx", 32'(hit_idx), eh ? 32'(ei) : 32'(last_idx));
        chk("alive", 32'(alive), 32'(ea));
        chk("cleared_e16", 32'(cleared), 32'(alive_m == 15'd0));
      end else begin
        chk("done_fall", 32'(done), 32'd0);
        chk("hit_fall", 32'(hit), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("cleared", 32'(cleared), 32'(ea == 15'd0));
      end
    end
    alive_m = ea;
    if (eh) last_idx = ei;
  endtask

  task automatic kill(input int k);
    run_scan(blk_x(k) + 10, blk_y(k), 0, -1);
  endtask

  task automatic idle_watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("no_done", 32'(done), 32'd0);
      chk("no_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_restart(input logic with_start);
    @(negedge clk);
    restart = 1'b1;
    start   = with_start;
    @(posedge clk); #1;
    restart = 1'b0;
    start   = 1'b0;
    alive_m = 15'h7FFF;
    chk("restart_alive", 32'(alive), 32'h7FFF);
    chk("restart_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 15; k++) rom_tbl[k] = {10'(blk_x(k)), 9'(blk_y(k))};
    rom_tbl[15] = '0;
    rst = 1'b1; start = 1'b0; restart = 1'b0; ball_x = '0; ball_y = '0;
    alive_m = 15'h7FFF;
    last_idx = 0;
    #12;
    chk("rst_alive", 32'(alive), 32'h7FFF);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hit_idx", 32'(hit_idx), 32'd0);
    chk("rst_cleared", 32'(cleared), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(2);

    // Direct hit on block 0
    run_scan(110, 322, 0, -1);
    chk("alive_7ffe", 32'(alive), 32'h7FFE);

    // Gap between blocks 0 and 1
    do_restart(1'b0);
    run_scan(182, 322, 0, -1);
    chk("gap_alive", 32'(alive), 32'h7FFF);

    // Ball straddling blocks 1 and 6, three scans in a row
    run_scan(185, 326, 0, -1);
    chk("ovl_alive1", 32'(alive), 32'h7FFD);
    run_scan(185, 326, 0, -1);
    chk("ovl_alive2", 32'(alive), 32'h7FBD);
    run_scan(185, 326, 0, -1);

    // Re-start mid-scan ignored, ball moved mid-scan ignored
    run_scan(110, 322, 5, 20);
    idle_watch(20);

    // Restart at edge 8 with blocks 0..3 dead
    kill(2);
    kill(3);
    chk("pre_restart_alive", 32'(alive), 32'h7FB0);
    @(negedge clk);
    ball_x = 10'(blk_x(4) + 5); ball_y = 9'(blk_y(4)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      restart = (e == 8);
      @(posedge clk); #1;
    end
    restart = 1'b0;
    alive_m = 15'h7FFF;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_alive", 32'(alive), 32'h7FFF);
    chk("abort_addr", 32'(rom_addr), 32'd0);
    chk("abort_hit_idx", 32'(hit_idx), 32'(last_idx));
    idle_watch(20);

    // Restart wins over a coincident start
    do_restart(1'b1);
    idle_watch(3);

    // Async reset at edge 8 of a scan
    kill(7);
    @(negedge clk);
    ball_x = 10'(blk_x(4) + 5); ball_y = 9'(blk_y(4)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_alive", 32'(alive), 32'h7FFF);
    chk("mrst_addr", 32'(rom_addr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_hit", 32'(hit), 32'd0);
    chk("mrst_hit_idx", 32'(hit_idx), 32'd0);
    chk("mrst_cleared", 32'(cleared), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    alive_m = 15'h7FFF;
    last_idx = 0;
    idle_watch(20);
    kill(4);

    // Random placements around the wall
    do_restart(1'b0);
    for (int n = 0; n < 40; n++) begin
      int k;
      int x;
      int y;
      if (alive_m == 15'd0) do_restart(1'b0);
      k = int'($urandom_range(14, 0));
      x = blk_x(k) + int'($urandom_range(96, 0)) - 12;
      y = blk_y(k) + int'($urandom_range(20, 0)) - 10;
      run_scan(x, y, 0, -1);
    end

    // Clear the whole wall, then scan an empty field
    do_restart(1'b0);
    for (int k = 0; k < 15; k++) kill(k);
    chk("all_dead", 32'(alive), 32'd0);
    chk("cleared_set", 32'(cleared), 32'd1);
    run_scan(110, 322, 0, -1);
    run_scan(185, 326, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
